// File: rtl/ysyx_22050243_clint_if.sv
// Single-outstanding request/response bus between the MEM stage and the CLINT.
interface ysyx_22050243_clint_if #(
    parameter int ADDR_WIDTH      = 16,
    parameter int DBUS_DATA_WIDTH = 64
) ();
    logic                           req_valid;
    logic                           req_ready;
    logic                           req_wen;
    logic [ADDR_WIDTH-1:0]          req_addr;
    logic [DBUS_DATA_WIDTH-1:0]     req_wdata;
    logic [DBUS_DATA_WIDTH/8-1:0]   req_wstrb;
    logic                           resp_valid;
    logic                           resp_ready;
    logic [DBUS_DATA_WIDTH-1:0]     resp_rdata;
    logic                           resp_err;

    modport master (
        output req_valid, req_wen, req_addr, req_wdata, req_wstrb, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_wen, req_addr, req_wdata, req_wstrb, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/ysyx_22050243_clint.sv
// Core-local interruptor: mtime/mtimecmp/msip behind a two-state request/response FSM,
// producing the machine timer and software interrupt levels for the WB stage.
module ysyx_22050243_clint #(
    parameter int ADDR_WIDTH      = 16,
    parameter int DBUS_DATA_WIDTH = 64,
    parameter int TICK_DIV        = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    ysyx_22050243_clint_if.slave    bus,
    output logic                    clint_timer_irq,
    output logic                    clint_soft_irq
);
    localparam int DW = DBUS_DATA_WIDTH;
    localparam int SW = DBUS_DATA_WIDTH / 8;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [ADDR_WIDTH-1:0] MSIP_OFF     = ADDR_WIDTH'(32'h0000);
    localparam logic [ADDR_WIDTH-1:0] MTIMECMP_OFF = ADDR_WIDTH'(32'h4000);
    localparam logic [ADDR_WIDTH-1:0] MTIME_OFF    = ADDR_WIDTH'(32'hBFF8);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RESP = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [DW-1:0]        mtime_q, mtime_d;
    logic [DW-1:0]        mtimecmp_q, mtimecmp_d;
    logic                 msip_q, msip_d;
    logic [PW-1:0]        presc_q, presc_d;
    logic [DW-1:0]        resp_rdata_q, resp_rdata_d;
    logic                 resp_err_q, resp_err_d;
    logic                 timer_irq_q;

    logic                 tick;
    logic                 fire;
    logic                 wr;
    logic [ADDR_WIDTH-4:0] word;
    logic                 hit_msip, hit_cmp, hit_mtime, hit_any;
    logic [DW-1:0]        wmask;
    logic [DW-1:0]        rd_mux;
    logic                 unused_addr_lsb;

    // Offsets are 8-byte aligned; the low address bits carry no information.
    assign unused_addr_lsb = ^bus.req_addr[2:0];
    assign word            = bus.req_addr[ADDR_WIDTH-1:3];

    assign hit_msip  = (word == MSIP_OFF[ADDR_WIDTH-1:3]);
    assign hit_cmp   = (word == MTIMECMP_OFF[ADDR_WIDTH-1:3]);
    assign hit_mtime = (word == MTIME_OFF[ADDR_WIDTH-1:3]);
    assign hit_any   = hit_msip | hit_cmp | hit_mtime;

    generate
        for (genvar gi = 0; gi < SW; gi++) begin : g_wmask
            assign wmask[gi*8 +: 8] = {8{bus.req_wstrb[gi]}};
        end
    endgenerate

    assign tick    = (presc_q == PW'(TICK_DIV - 1));
    assign presc_d = tick ? '0 : presc_q + 1'b1;

    always_comb begin
        state_d = state_q;
        fire    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    fire    = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.resp_ready) begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        rd_mux       = '0;
        wr           = fire & bus.req_wen;
        msip_d       = msip_q;
        mtimecmp_d   = mtimecmp_q;
        mtime_d      = mtime_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;

        if (hit_msip) begin
            rd_mux = {{(DW-1){1'b0}}, msip_q};
        end else if (hit_cmp) begin
            rd_mux = mtimecmp_q;
        end else if (hit_mtime) begin
            rd_mux = mtime_q;
        end

        if (wr && hit_msip && bus.req_wstrb[0]) begin
            msip_d = bus.req_wdata[0];
        end
        if (wr && hit_cmp) begin
            mtimecmp_d = (mtimecmp_q & ~wmask) | (bus.req_wdata & wmask);
        end
        // A store on a tick edge wins: unwritten bytes keep the pre-tick value.
        if (wr && hit_mtime) begin
            mtime_d = (mtime_q & ~wmask) | (bus.req_wdata & wmask);
        end else if (tick) begin
            mtime_d = mtime_q + DW'(1);
        end

        if (fire) begin
            resp_rdata_d = bus.req_wen ? '0 : rd_mux;
            resp_err_d   = ~hit_any;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            mtime_q      <= '0;
            mtimecmp_q   <= '1;
            msip_q       <= 1'b0;
            presc_q      <= '0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            timer_irq_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            mtime_q      <= mtime_d;
            mtimecmp_q   <= mtimecmp_d;
            msip_q       <= msip_d;
            presc_q      <= presc_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            timer_irq_q  <= (mtime_q >= mtimecmp_q);
        end
    end

    assign bus.req_ready   = (state_q == S_IDLE);
    assign bus.resp_valid  = (state_q == S_RESP);
    assign bus.resp_rdata  = resp_rdata_q;
    assign bus.resp_err    = resp_err_q;
    assign clint_timer_irq = timer_irq_q;
    assign clint_soft_irq  = msip_q;
endmodule

// File: tb/tb_ysyx_22050243_clint.sv
// Directed bench for the CLINT: a register-access vector table plus hand-timed
// sequences for mtime ticking, wrap, timer irq timing, tick-edge stores and reset.
module tb_ysyx_22050243_clint;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    ysyx_22050243_clint_if #(.ADDR_WIDTH(16), .DBUS_DATA_WIDTH(64)) bus0 ();
    ysyx_22050243_clint_if #(.ADDR_WIDTH(16), .DBUS_DATA_WIDTH(64)) bus4 ();

    logic timer0, soft0, timer4, soft4;

    ysyx_22050243_clint #(.ADDR_WIDTH(16), .DBUS_DATA_WIDTH(64), .TICK_DIV(1)) u_dut0 (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus0),
        .clint_timer_irq (timer0),
        .clint_soft_irq  (soft0)
    );

    ysyx_22050243_clint #(.ADDR_WIDTH(16), .DBUS_DATA_WIDTH(64), .TICK_DIV(4)) u_dut4 (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus4),
        .clint_timer_irq (timer4),
        .clint_soft_irq  (soft4)
    );

    int checks   = 0;
    int failures = 0;
    int unsigned cyc;

    // Edges since reset release; used only to line a store up with a TICK_DIV=4 tick edge.
    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    typedef struct {
        logic        wen;
        logic [15:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
        logic [63:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[19];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    // Presents a request at the current negedge; it is accepted on the next posedge.
    // Response side is sampled one negedge later, and the task returns one cycle after
    // that, with the DUT back in IDLE (resp_ready is held high).
    task automatic xact(input int sel, input logic wen, input logic [15:0] addr,
                        input logic [63:0] wd, input logic [7:0] ws,
                        output logic [63:0] rd, output logic err, output logic rv,
                        output logic tirq, output logic sirq);
        if (sel == 0) begin
            bus0.req_valid = 1'b1; bus0.req_wen = wen; bus0.req_addr = addr;
            bus0.req_wdata = wd;   bus0.req_wstrb = ws;
        end else begin
            bus4.req_valid = 1'b1; bus4.req_wen = wen; bus4.req_addr = addr;
            bus4.req_wdata = wd;   bus4.req_wstrb = ws;
        end
        @(negedge clk);
        if (sel == 0) begin
            bus0.req_valid = 1'b0;
            rd = bus0.resp_rdata; err = bus0.resp_err; rv = bus0.resp_valid;
            tirq = timer0; sirq = soft0;
        end else begin
            bus4.req_valid = 1'b0;
            rd = bus4.resp_rdata; err = bus4.resp_err; rv = bus4.resp_valid;
            tirq = timer4; sirq = soft4;
        end
        $display("xact dut%0d %s addr=0x%04h wdata=0x%016h wstrb=0x%02h -> rdata=0x%016h err=%b",
                 sel, wen ? "ST" : "LD", addr, wd, ws, rd, err);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] rd;
        logic        err, rv, ti, si;

        rst = 1'b1;
        bus0.req_valid = 1'b0; bus0.req_wen = 1'b0; bus0.req_addr = '0;
        bus0.req_wdata = '0;   bus0.req_wstrb = '0; bus0.resp_ready = 1'b1;
        bus4.req_valid = 1'b0; bus4.req_wen = 1'b0; bus4.req_addr = '0;
        bus4.req_wdata = '0;   bus4.req_wstrb = '0; bus4.resp_ready = 1'b1;

        vecs[0]  = '{1'b1, 16'h0000, 64'h0,                   8'hFE, 64'h0,                   1'b0};
        vecs[1]  = '{1'b0, 16'h0000, 64'h0,                   8'h00, 64'h1,                   1'b0};
        vecs[2]  = '{1'b1, 16'h0004, 64'h0,                   8'h01, 64'h0,                   1'b0};
        vecs[3]  = '{1'b0, 16'h0000, 64'h0,                   8'h00, 64'h0,                   1'b0};
        vecs[4]  = '{1'b1, 16'h0000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 64'h0,                   1'b0};
        vecs[5]  = '{1'b0, 16'h0000, 64'h0,                   8'h00, 64'h1,                   1'b0};
        vecs[6]  = '{1'b1, 16'h4000, 64'h1122_3344_5566_7788, 8'hFF, 64'h0,                   1'b0};
        vecs[7]  = '{1'b0, 16'h4000, 64'h0,                   8'h00, 64'h1122_3344_5566_7788, 1'b0};
        vecs[8]  = '{1'b1, 16'h4000, 64'h0000_0000_0000_00AA, 8'h01, 64'h0,                   1'b0};
        vecs[9]  = '{1'b1, 16'h4000, 64'hBBCC_0000_0000_0000, 8'hC0, 64'h0,                   1'b0};
        vecs[10] = '{1'b0, 16'h4004, 64'h0,                   8'h00, 64'hBBCC_3344_5566_77AA, 1'b0};
        vecs[11] = '{1'b0, 16'h1234, 64'h0,                   8'h00, 64'h0,                   1'b1};
        vecs[12] = '{1'b1, 16'h1238, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 64'h0,                   1'b1};
        vecs[13] = '{1'b1, 16'h8000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 64'h0,                   1'b1};
        vecs[14] = '{1'b0, 16'h4000, 64'h0,                   8'h00, 64'hBBCC_3344_5566_77AA, 1'b0};
        vecs[15] = '{1'b0, 16'h0000, 64'h0,                   8'h00, 64'h1,                   1'b0};
        vecs[16] = '{1'b0, 16'hFFF8, 64'h0,                   8'h00, 64'h0,                   1'b1};
        vecs[17] = '{1'b1, 16'h0000, 64'h0,                   8'h01, 64'h0,                   1'b0};
        vecs[18] = '{1'b0, 16'h0000, 64'h0,                   8'h00, 64'h0,                   1'b0};

        repeat (3) @(negedge clk);

        // Reset state
        chk_bit("rst_req_ready0",  bus0.req_ready,  1'b1);
        chk_bit("rst_resp_valid0", bus0.resp_valid, 1'b0);
        chk    ("rst_rdata0",      bus0.resp_rdata, 64'h0);
        chk_bit("rst_err0",        bus0.resp_err,   1'b0);
        chk_bit("rst_timer0",      timer0,          1'b0);
        chk_bit("rst_soft0",       soft0,           1'b0);
        chk_bit("rst_req_ready4",  bus4.req_ready,  1'b1);
        chk_bit("rst_resp_valid4", bus4.resp_valid, 1'b0);
        rst = 1'b0;

        // mtime counts one per edge; the load is accepted on the 11th edge and sees 10.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk_bit("t1_timer_idle", timer0, 1'b0);
        end
        xact(0, 1'b0, 16'hBFF8, 64'h0, 8'h00, rd, err, rv, ti, si);
        chk_bit("t1_resp_valid", rv, 1'b1);
        chk    ("t1_mtime",      rd, 64'd10);
        chk_bit("t1_err",        err, 1'b0);
        chk_bit("t1_timer",      ti, 1'b0);

        // Software interrupt visible the cycle after the msip store
        chk_bit("t5_soft_before", soft0, 1'b0);
        xact(0, 1'b1, 16'h0000, 64'h1, 8'h01, rd, err, rv, ti, si);
        chk_bit("t5_soft_after", si, 1'b1);
        chk    ("t5_store_rdata", rd, 64'h0);

        for (int i = 0; i < 19; i++) begin
            xact(0, vecs[i].wen, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, rd, err, rv, ti, si);
            chk_bit($sformatf("vec%0d_valid", i), rv,  1'b1);
            chk    ($sformatf("vec%0d_rdata", i), rd,  vecs[i].exp_rdata);
            chk_bit($sformatf("vec%0d_err",   i), err, vecs[i].exp_err);
        end

        // mtime=0 at edge P, mtimecmp=0x20 at P+2; mtime hits 0x20 after P+32, irq after P+33.
        xact(0, 1'b1, 16'hBFF8, 64'h0,  8'hFF, rd, err, rv, ti, si);
        xact(0, 1'b1, 16'h4000, 64'h20, 8'hFF, rd, err, rv, ti, si);
        chk_bit("t2_timer_at_store", ti, 1'b0);
        for (int k = 1; k <= 34; k++) begin
            @(negedge clk);
            chk_bit($sformatf("t2_timer_k%0d", k), timer0, (k >= 30));
        end
        xact(0, 1'b1, 16'h4000, 64'h1000, 8'hFF, rd, err, rv, ti, si);
        chk_bit("t2_timer_hold_1cyc", ti, 1'b1);
        chk_bit("t2_timer_drop_2cyc", timer0, 1'b0);

        // Wrap: FFFE at S, FFFF at S+1, 0 at S+2; irq follows one edge behind.
        xact(0, 1'b1, 16'hBFF8, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, rd, err, rv, ti, si);
        chk_bit("t3_timer_at_store", ti, 1'b0);
        chk_bit("t3_timer_set", timer0, 1'b1);
        @(negedge clk);
        chk_bit("t3_timer_hold", timer0, 1'b1);
        xact(0, 1'b0, 16'hBFF8, 64'h0, 8'h00, rd, err, rv, ti, si);
        chk    ("t3_wrap_mtime", rd, 64'h0);
        chk_bit("t3_timer_drop", ti, 1'b0);

        // TICK_DIV=4: ticks on edges where cyc becomes a multiple of 4.
        xact(1, 1'b1, 16'hBFF8, 64'h1122_3344_5566_7700, 8'hFF, rd, err, rv, ti, si);
        for (int i = 0; i < 4 && ((cyc + 1) % 4) != 0; i++) @(negedge clk);
        xact(1, 1'b1, 16'hBFF8, 64'h55, 8'h01, rd, err, rv, ti, si);
        xact(1, 1'b0, 16'hBFF8, 64'h0, 8'h00, rd, err, rv, ti, si);
        chk("t4_tick_edge_store", rd, 64'h1122_3344_5566_7755);
        xact(1, 1'b0, 16'hBFF8, 64'h0, 8'h00, rd, err, rv, ti, si);
        chk("t4_before_next_tick", rd, 64'h1122_3344_5566_7755);
        xact(1, 1'b0, 16'hBFF8, 64'h0, 8'h00, rd, err, rv, ti, si);
        chk("t4_after_next_tick", rd, 64'h1122_3344_5566_7756);

        // Stalled error response, then reset while in RESP.
        xact(0, 1'b1, 16'h0000, 64'h1, 8'h01, rd, err, rv, ti, si);
        bus0.resp_ready = 1'b0;
        bus0.req_valid  = 1'b1;
        bus0.req_wen    = 1'b0;
        bus0.req_addr   = 16'h1234;
        @(negedge clk);
        bus0.req_addr = 16'h4000;
        chk_bit("t6_resp_valid", bus0.resp_valid, 1'b1);
        chk_bit("t6_resp_err",   bus0.resp_err,   1'b1);
        chk    ("t6_resp_rdata", bus0.resp_rdata, 64'h0);
        chk_bit("t6_req_ready",  bus0.req_ready,  1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_bit($sformatf("t6_hold%0d_valid", i), bus0.resp_valid, 1'b1);
            chk_bit($sformatf("t6_hold%0d_err",   i), bus0.resp_err,   1'b1);
            chk    ($sformatf("t6_hold%0d_rdata", i), bus0.resp_rdata, 64'h0);
            chk_bit($sformatf("t6_hold%0d_ready", i), bus0.req_ready,  1'b0);
        end
        bus0.req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk_bit("t6_rst_resp_valid", bus0.resp_valid, 1'b0);
        chk_bit("t6_rst_req_ready",  bus0.req_ready,  1'b1);
        chk_bit("t6_rst_err",        bus0.resp_err,   1'b0);
        chk_bit("t6_rst_soft",       soft0,           1'b0);
        rst = 1'b0;
        bus0.resp_ready = 1'b1;
        xact(0, 1'b0, 16'h0000, 64'h0, 8'h00, rd, err, rv, ti, si);
        chk_bit("t6_post_rst_valid", rv, 1'b1);
        chk    ("t6_post_rst_msip",  rd, 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ysyx_22050243_clint.md
Name: ysyx_22050243_clint

Overview:
Core-local interruptor for the single-hart core. Holds mtime, mtimecmp and msip, and answers data-bus loads/stores from the MEM stage. It drives clint_timer_irq and clint_soft_irq to the WB-stage exception/interrupt detection, which gates them with mstatus.MIE and mie.
Memory-mapped CSR-style peripheral with single-outstanding request handshake and 64-bit data lanes.

Parameters:
ADDR_WIDTH, 16, byte offset width within the CLINT window; upper address bits are decoded outside this block.
DBUS_DATA_WIDTH, 64, data bus width; fixed at 64.
TICK_DIV, 1, core cycles per mtime increment; legal range 1..65535.

Ports:
clk  input  1  core clock
rst  input  1  synchronous active-high reset
req_valid  input  1  bus request valid
req_ready  output  1  block can accept a request
req_wen  input  1  1 = store, 0 = load
req_addr  input  ADDR_WIDTH  byte offset; bits[2:0] ignored (8-byte aligned)
req_wdata  input  64  store data
req_wstrb  input  8  byte enables for stores
resp_valid  output  1  response valid
resp_ready  input  1  requester accepts response
resp_rdata  output  64  load data (0 for stores)
resp_err  output  1  unmapped offset
clint_timer_irq  output  1  registered (mtime >= mtimecmp)
clint_soft_irq  output  1  msip bit 0

Behaviour:
- Register map (offset[ADDR_WIDTH-1:3]):
  - 0x0000: msip. Bit 0 is RW; bits 63:1 read as 0.
  - 0x4000: mtimecmp, 64-bit RW.
  - 0xBFF8: mtime, 64-bit RW.
  - Any other offset is unmapped.
- Reset values: mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, msip=0, prescaler=0, clint_timer_irq=0, clint_soft_irq=0, resp_valid=0, resp_rdata=0, resp_err=0. State is IDLE and req_ready=1.
- Reset mid-transaction drops any pending response. Reset has priority over everything.
- FSM, two states:
  - IDLE: req_ready=1. On req_valid: latch request, perform the access this edge, go to RESP.
  - RESP: req_ready=0, resp_valid=1, resp_rdata/resp_err held stable. On resp_ready: go to IDLE.
  - Latency: request accepted at cycle N gives resp_valid at N+1. Back-to-back throughput is 1 request per 2 cycles.
- Loads:
  - resp_rdata is the register value before any same-edge tick.
  - Unmapped offset: rdata=0, resp_err=1.
- Stores:
  - Byte-granular by req_wstrb.
  - msip updates only from wstrb[0], bit 0.
  - Unmapped offset: no state change, resp_err=1, rdata=0.
- Prescaler and mtime:
  - The prescaler counts 0..TICK_DIV-1. On wrap, mtime increments by 1, modulo 2^64: all-ones wraps to 0 with no flag.
  - A store to mtime on the same edge as a tick wins. mtime takes the written bytes, unwritten bytes keep their pre-tick value, and no increment occurs that edge.
  - The prescaler is not reset by mtime writes.
- clint_timer_irq:
  - Registered each cycle from (mtime >= mtimecmp), unsigned 64-bit compare, using current register values.
  - It therefore lags a register change by 1 cycle and is level, not pulse.
  - Cleared only by making the compare false (write larger mtimecmp, or smaller mtime).
- clint_soft_irq: equals msip bit 0 directly from the register, so it is visible the cycle after the store.
- req_valid while in RESP is ignored because req_ready=0. The requester must hold the request until accepted.

Test Plan:
1. Reset, TICK_DIV=1, idle 10 cycles -> mtime load returns 10 (±handshake cycles counted exactly); clint_timer_irq=0 throughout.
2. Store mtimecmp=0x20 with wstrb=0xFF, then wait -> clint_timer_irq rises exactly 1 cycle after mtime reaches 0x20 and stays 1. Store mtimecmp=0x1000 -> irq drops 2 cycles after acceptance.
3. Store mtime=0xFFFF_FFFF_FFFF_FFFE -> after 2 ticks, load returns 0. Irq stays set while mtimecmp <= mtime, and drops once mtime wraps below mtimecmp.
4. TICK_DIV=4, store mtime=0x55 (wstrb=0x01) on the exact tick edge -> mtime byte0=0x55, upper bytes unchanged, no increment that edge; next increment 4 cycles later.
5. Store msip=1 -> clint_soft_irq=1 the next cycle. Store with wstrb=0xFE -> msip unchanged. Load offset 0x0000 returns 64'h1.
6. Load offset 0x1234 -> resp_err=1, rdata=0. Hold resp_ready=0 for 3 cycles -> resp_valid, resp_err and rdata stay stable and req_ready=0. Assert rst while in RESP -> next cycle resp_valid=0 and req_ready=1.
